// File: rtl/wb_arbiter.sv
// Write-back arbiter with destination scoreboard: round-robin between ALU and load
// write-back, tracks pending-write registers and stalls WAW claims.
module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              rd_we,
  output logic [AW-1:0]     rd,
  output logic [DATA_W-1:0] rd_data,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  logic [NREG-1:0]   busy_r;
  logic              err_r;
  logic              last_alu_r;
  logic              rd_we_r;
  logic [AW-1:0]     rd_r;
  logic [DATA_W-1:0] rd_data_r;

  logic              alu_gnt_s;
  logic              ld_gnt_s;
  logic              iss_gnt_s;
  logic              wb_acc_s;
  logic              wb_write_s;
  logic              contended_s;
  logic [AW-1:0]     wb_rd_s;
  logic [DATA_W-1:0] wb_data_s;
  logic [NREG-1:0]   busy_nxt_s;
  logic              err_nxt_s;

  // Grant selection, claim acceptance and scoreboard next-state.
  always_comb begin
    alu_gnt_s   = 1'b0;
    ld_gnt_s    = 1'b0;
    iss_gnt_s   = 1'b0;
    contended_s = 1'b0;
    wb_rd_s     = {AW{1'b0}};
    wb_data_s   = {DATA_W{1'b0}};
    busy_nxt_s  = busy_r;
    err_nxt_s   = err_r;

    if (rst) begin
      alu_gnt_s = 1'b0;
      ld_gnt_s  = 1'b0;
      iss_gnt_s = 1'b0;
    end else begin
      contended_s = alu_valid & ld_valid;
      // On contention the pointer names the last winner; the other side goes now.
      if (contended_s) begin
        alu_gnt_s = ~last_alu_r;
        ld_gnt_s  = last_alu_r;
      end else begin
        alu_gnt_s = alu_valid;
        ld_gnt_s  = ld_valid;
      end
      iss_gnt_s = iss_valid & ((iss_rd == {AW{1'b0}}) | ~busy_r[iss_rd]);
    end

    if (ld_gnt_s) begin
      wb_rd_s   = ld_rd;
      wb_data_s = ld_data;
    end else begin
      wb_rd_s   = alu_rd;
      wb_data_s = alu_data;
    end

    wb_acc_s   = alu_gnt_s | ld_gnt_s;
    wb_write_s = wb_acc_s & (wb_rd_s != {AW{1'b0}});

    // Clear before set: a same-register claim is already refused by busy, so
    // the only overlap is an erroneous write-back racing a legal claim.
    if (wb_write_s) begin
      busy_nxt_s[wb_rd_s] = 1'b0;
      if (!busy_r[wb_rd_s]) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end else begin
      busy_nxt_s = busy_r;
    end

    if (iss_gnt_s && (iss_rd != {AW{1'b0}})) begin
      busy_nxt_s[iss_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // State registers: scoreboard, sticky error, round-robin pointer, write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= {NREG{1'b0}};
      err_r      <= 1'b0;
      last_alu_r <= 1'b1;
      rd_we_r    <= 1'b0;
      rd_r       <= {AW{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      err_r   <= err_nxt_s;
      rd_we_r <= wb_write_s;
      if (contended_s) begin
        last_alu_r <= alu_gnt_s;
      end
      if (wb_write_s) begin
        rd_r      <= wb_rd_s;
        rd_data_r <= wb_data_s;
      end
    end
  end

  assign iss_ready = iss_gnt_s;
  assign alu_ready = alu_gnt_s;
  assign ld_ready  = ld_gnt_s;
  assign rd_we     = rd_we_r;
  assign rd        = rd_r;
  assign rd_data   = rd_data_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule
